sync_fifo_flags: RTL

Parametrised single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy count, overflow/underflow error pulses, and a selectable read mode: registered read or first-word-fall-through (FWFT). It is the same-clock companion of the team's dual-clock FIFO and buffers streams between blocks in one clock domain. Storage is an internal register array, and all flags derive from a registered occupancy counter.

---
 rtl/sync_fifo_flags.sv | 95 +++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with a register-array store, occupancy-derived flags,
// programmable almost thresholds, error pulses and a registered or FWFT read port.
module sync_fifo_flags #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       winc,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rinc,
  output logic [WIDTH-1:0]           rdata,
  output logic                       wfull,
  output logic                       rempty,
  output logic                       walmost_full,
  output logic                       ralmost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_waddr;
  logic [AW-1:0]    r_raddr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_wenc;
  logic             w_renc;

  // Flags decode only the registered count, so they change one edge after the cause.
  assign wfull         = (r_count == CW'(DEPTH));
  assign rempty        = (r_count == '0);
  assign walmost_full  = (r_count >= CW'(AFULL_TH));
  assign ralmost_empty = (r_count <= CW'(AEMPTY_TH));
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

  assign w_wenc = winc & ~wfull;
  assign w_renc = rinc & ~rempty;

  always_ff @(posedge clk) begin
    if (w_wenc) begin
      r_mem[r_waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_waddr     <= '0;
      r_raddr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= winc & wfull;
      r_underflow <= rinc & rempty;
      if (w_wenc) begin
        r_waddr <= (r_waddr == AW'(DEPTH - 1)) ? '0 : r_waddr + 1'b1;
      end
      if (w_renc) begin
        r_raddr <= (r_raddr == AW'(DEPTH - 1)) ? '0 : r_raddr + 1'b1;
      end
      case ({w_wenc, w_renc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = r_mem[r_raddr];
    end else begin : g_reg
      logic [WIDTH-1:0] r_rdata;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rdata <= '0;
        end else if (w_renc) begin
          r_rdata <= r_mem[r_raddr];
        end
      end
      assign rdata = r_rdata;
    end
  endgenerate

endmodule
